// File: rtl/pulse_measure_if.sv
// Result channel of pulse_measure: measured length plus status flags,
// offered by the producer on a valid/ready handshake.
interface pulse_measure_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] length;
  logic             overflow;
  logic             dropped;
  logic             valid;
  logic             ready;

  modport master (output length, output overflow, output dropped, output valid, input ready);
  modport slave  (input length, input overflow, input dropped, input valid, output ready);
endinterface

// File: rtl/pulse_measure.sv
// Counts how many cycles a synchronized input stays high and hands the
// result to a consumer, with glitch rejection, saturation and drop reporting.
module pulse_measure #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MIN_WIDTH = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in,
  output logic              busy,
  pulse_measure_if.master   res
);

  typedef enum logic [1:0] {IDLE, MEASURE, HOLD} state_t;

  localparam logic [WIDTH-1:0] MAX_CNT = '1;
  localparam logic [WIDTH-1:0] MIN_CNT = WIDTH'(MIN_WIDTH);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic             prev;
  logic             sat;
  logic             pending_drop;
  logic             rise;

  assign rise = in && !prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      prev         <= 1'b1;
      sat          <= 1'b0;
      pending_drop <= 1'b0;
      busy         <= 1'b0;
      res.length   <= '0;
      res.overflow <= 1'b0;
      res.dropped  <= 1'b0;
      res.valid    <= 1'b0;
    end else begin
      prev <= in;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= MEASURE;
            count <= WIDTH'(1);
            busy  <= 1'b1;
          end
        end
        MEASURE: begin
          if (in) begin
            if (count == MAX_CNT) sat <= 1'b1;
            else                  count <= count + 1'b1;
          end else if (count < MIN_CNT) begin
            state <= IDLE;
            busy  <= 1'b0;
            sat   <= 1'b0;
          end else begin
            res.length   <= count;
            res.overflow <= sat;
            res.dropped  <= pending_drop;
            res.valid    <= 1'b1;
            busy         <= 1'b0;
            sat          <= 1'b0;
            pending_drop <= 1'b0;
            state        <= HOLD;
          end
        end
        HOLD: begin
          if (res.ready) begin
            res.valid <= 1'b0;
            // A rise coinciding with the accept starts a fresh measurement.
            if (rise) begin
              state <= MEASURE;
              count <= WIDTH'(1);
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end else if (rise) begin
            pending_drop <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_measure.sv
// Drives two pulse_measure instances (16-bit/min 1 and 4-bit/min 3) with the
// same directed and random stimulus and compares every cycle to a pulse model.
module tb_pulse_measure;

  logic clk = 1'b0;
  logic reset;
  logic sig;
  logic rdy;
  logic busy_a, busy_b;

  always #5 clk = ~clk;

  pulse_measure_if #(.WIDTH(16)) ifa ();
  pulse_measure_if #(.WIDTH(4))  ifb ();

  assign ifa.ready = rdy;
  assign ifb.ready = rdy;

  pulse_measure #(.WIDTH(16), .MIN_WIDTH(1)) dut_a (
    .clk(clk), .reset(reset), .in(sig), .busy(busy_a), .res(ifa.master)
  );

  pulse_measure #(.WIDTH(4), .MIN_WIDTH(3)) dut_b (
    .clk(clk), .reset(reset), .in(sig), .busy(busy_b), .res(ifb.master)
  );

  // Model view: the true (unbounded) width of the current high run, plus
  // the result currently offered to the consumer.
  typedef struct {
    bit          prev;
    bit          meas;
    int unsigned run;
    bit          pend;
    bit          val;
    int unsigned len;
    bit          ovf;
    bit          drp;
  } mdl_t;

  mdl_t ma, mb;
  int unsigned checks = 0;
  int unsigned failures = 0;

  function automatic mdl_t mstep(mdl_t m, bit i, bit r, bit rst, int unsigned maxv, int unsigned minv);
    mdl_t n;
    bit rise;
    n = m;
    if (rst) begin
      n = '{prev: 1'b1, meas: 1'b0, run: 0, pend: 1'b0, val: 1'b0, len: 0, ovf: 1'b0, drp: 1'b0};
      return n;
    end
    rise = i && !m.prev;
    if (m.val) begin
      if (r) begin
        n.val = 1'b0;
        if (rise) begin
          n.meas = 1'b1;
          n.run  = 1;
        end
      end else if (rise) begin
        n.pend = 1'b1;
      end
    end else if (m.meas) begin
      if (i) begin
        n.run = m.run + 1;
      end else begin
        n.meas = 1'b0;
        if (m.run >= minv) begin
          n.val  = 1'b1;
          n.len  = (m.run > maxv) ? maxv : m.run;
          n.ovf  = (m.run > maxv);
          n.drp  = m.pend;
          n.pend = 1'b0;
        end
      end
    end else if (rise) begin
      n.meas = 1'b1;
      n.run  = 1;
    end
    n.prev = i;
    return n;
  endfunction

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    ma = mstep(ma, sig, rdy, reset, 65535, 1);
    mb = mstep(mb, sig, rdy, reset, 15, 3);
    #1;
    check("A.valid",    32'(ifa.valid),    32'(ma.val));
    check("A.busy",     32'(busy_a),       32'(ma.meas));
    check("A.length",   32'(ifa.length),   ma.len);
    check("A.overflow", 32'(ifa.overflow), 32'(ma.ovf));
    check("A.dropped",  32'(ifa.dropped),  32'(ma.drp));
    check("B.valid",    32'(ifb.valid),    32'(mb.val));
    check("B.busy",     32'(busy_b),       32'(mb.meas));
    check("B.length",   32'(ifb.length),   mb.len);
    check("B.overflow", 32'(ifb.overflow), 32'(mb.ovf));
    check("B.dropped",  32'(ifb.dropped),  32'(mb.drp));
  endtask

  // rmode: 0 ready low, 1 ready high, 2 ready random each cycle
  task automatic drive(input int unsigned hi, input int unsigned lo, input int unsigned rmode);
    for (int unsigned k = 0; k < hi + lo; k++) begin
      sig = (k < hi);
      rdy = (rmode == 2) ? 1'($urandom_range(0, 1)) : (rmode == 1);
      step();
    end
  endtask

  task automatic do_reset(input int unsigned n);
    reset = 1'b1;
    for (int unsigned k = 0; k < n; k++) step();
    reset = 1'b0;
  endtask

  initial begin
    ma = '{prev: 1'b1, default: '0};
    mb = '{prev: 1'b1, default: '0};
    reset = 1'b1;
    sig   = 1'b0;
    rdy   = 1'b0;
    do_reset(2);
    drive(0, 2, 1);

    // basic 5-cycle pulse, immediate accept
    drive(5, 3, 1);
    // glitch rejection on B, then minimum accepted width
    drive(2, 3, 1);
    drive(3, 3, 1);
    // saturation boundary on B
    drive(15, 3, 1);
    drive(16, 3, 1);
    drive(20, 3, 1);
    // drop while result held, then next result carries dropped
    drive(4, 2, 0);
    drive(2, 2, 0);
    drive(0, 2, 1);
    drive(6, 3, 1);
    // rise in the same cycle as the accept
    drive(4, 2, 0);
    sig = 1'b1; rdy = 1'b1; step();
    drive(2, 3, 1);
    // reset mid-measure with the line held high through release
    drive(7, 0, 1);
    sig = 1'b1;
    do_reset(2);
    drive(4, 3, 1);
    drive(3, 3, 1);
    // reset mid-hold
    drive(4, 2, 0);
    sig = 1'b1;
    do_reset(1);
    drive(3, 2, 1);
    drive(4, 3, 1);

    for (int unsigned it = 0; it < 300; it++) begin
      if ($urandom_range(0, 39) == 0) begin
        sig = 1'($urandom_range(0, 1));
        do_reset(1);
      end
      drive($urandom_range(1, 20), $urandom_range(1, 4), $urandom_range(0, 2));
    end
    drive(0, 3, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_measure.md
Name: pulse_measure

Overview:
- Measures pulse width: counts how many clock cycles a single-bit input stays high.
- Complements the fixed-duration delay timer, which generates timed intervals; this block reads them back.
- Intended for checking timed strobes from peripherals, and for measuring in-system delays in tests.
- Results go to a consumer over a valid/ready handshake, with glitch rejection and saturation reporting.

Parameters:
- WIDTH, 16, width of the length result; the counter saturates at 2^WIDTH-1.
- MIN_WIDTH, 1, pulses shorter than this many cycles are discarded silently. Legal range 1..2^WIDTH-1.

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in  input  1  signal to measure. Already synchronized to clk by the caller; no internal synchronizer.
- length  output  WIDTH  measured high time in cycles. Stable while valid=1.
- overflow  output  1  the measurement saturated; the true width exceeded 2^WIDTH-1. Stable while valid=1.
- dropped  output  1  one or more pulses began while a result was waiting (HOLD). Reported with the next result.
- valid  output  1  a result is available.
- ready  input  1  consumer accepts the result when valid&&ready.
- busy  output  1  high while in MEASURE.

Behaviour:
- Reset (reset=1 at a clk edge):
  - state=IDLE.
  - count=0, length=0.
  - valid=0, overflow=0, dropped=0, busy=0.
  - prev=1, so a line already high out of reset is not treated as a rising edge.
  - Reset wins over every other event, including mid-MEASURE and mid-HOLD. Any partial or pending result is lost.
- prev holds in from the previous edge and updates every cycle. rise = in && !prev.
- IDLE:
  - On rise: go to MEASURE, count<=1, busy<=1.
  - Otherwise stay.
- MEASURE, each edge:
  - If in=1: count<=count+1, saturating at 2^WIDTH-1. An increment attempted at saturation sets an internal sat flag.
  - If in=0 and count<MIN_WIDTH: discard, go to IDLE, busy<=0. Nothing is output.
  - If in=0 and count>=MIN_WIDTH: length<=count, overflow<=sat, dropped<=pending_drop, valid<=1, busy<=0. Clear sat and pending_drop, go to HOLD.
- Latency: a pulse sampled high on N consecutive edges gives length=N. valid is asserted on the edge after the first low sample, i.e. one cycle after the falling edge is seen.
- HOLD:
  - valid=1; length, overflow and dropped are held.
  - A rise while valid&&!ready: the pulse is not measured; set pending_drop.
  - On valid&&ready: valid<=0. If rise occurs in that same cycle, go directly to MEASURE with count<=1 (the pulse is not dropped). Otherwise go to IDLE.
  - A pulse that began during HOLD and is still high after accept is never measured, because there is no new rise.
- MIN_WIDTH=1: every pulse is reported.
- Saturation:
  - A pulse of exactly 2^WIDTH-1 cycles reports length=2^WIDTH-1, overflow=0.
  - One cycle longer reports the same length with overflow=1.
- ready is ignored outside HOLD. valid never drops without a handshake, except on reset.
- Pulses are separated by at least one low sample, which is inherent in rise detection. Back-to-back pulses of the form 1,0,1 are both measured, provided the first result is accepted by the cycle the second rise is seen.

Test Plan:
1. Reset; in high for 5 cycles then low; ready=1 -> valid pulses one cycle, one cycle after the low sample, with length=5, overflow=0, dropped=0.
2. MIN_WIDTH=3; 2-cycle pulse, then 3-cycle pulse -> first pulse produces no valid; second gives length=3. busy is high for 2 and 3 cycles respectively.
3. WIDTH=4; 15-cycle pulse -> length=15, overflow=0. Then a 20-cycle pulse -> length=15, overflow=1.
4. ready=0; 4-cycle pulse, then a 2-cycle pulse during HOLD; ready=1 -> first result length=4, dropped=0. Next 6-cycle pulse -> length=6, dropped=1.
5. HOLD with rise in the same cycle as the valid&&ready accept -> that pulse is measured; 3-cycle pulse gives length=3, dropped=0.
6. reset asserted mid-MEASURE (count=7) and mid-HOLD, with in held high through reset deassertion -> all outputs 0 the edge after reset. No spurious measurement until in goes low then high again.
